memory_writeback: RTL

- Final CPU pipeline stage. It sits directly downstream of the decode/execute stage and consumes its DEX_* pipeline register outputs.
- It performs the data-memory access for LDR/ST through a ready/valid-style data-memory port.
- It selects the write-back value and drives the register file's two CPU write ports (we_CPU_0/1, wrt_addr_0/1, wrt_data_0/1).
- It generates MEM_STALL, which freezes upstream stages while an access is outstanding, and latches HALT.

---
 rtl/memory_writeback.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/memory_writeback.sv
// ---------------------------------------------------------------------------
// memory_writeback
//   Final CPU pipeline stage. Performs the data-memory access for loads and
//   stores, selects the write-back value and drives both register-file CPU
//   write ports. Raises MEM_STALL to freeze upstream stages while an access
//   is outstanding and latches HALT.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   DEX_*                   decode/execute pipeline register outputs
//   dmem_rdy, dmem_rdata    data-memory completion and load data
//   dmem_re/we/addr/wdata   registered data-memory request
//   we_CPU_x, wrt_addr_x,
//   wrt_data_x              registered register-file write ports 0 and 1
//   MEM_STALL               combinational upstream freeze
//   halted, mem_err         sticky status flags
// ---------------------------------------------------------------------------
module memory_writeback #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        DEX_alu_to_reg,
   input  logic        DEX_pcr_to_reg,
   input  logic        DEX_mem_to_reg,
   input  logic        DEX_imm_to_reg,
   input  logic        DEX_reg_we_dst_0,
   input  logic        DEX_reg_we_dst_1,
   input  logic        DEX_mem_we,
   input  logic        DEX_mem_re,
   input  logic        DEX_halt,
   input  logic [4:0]  DEX_dst_addr_0,
   input  logic [4:0]  DEX_dst_addr_1,
   input  logic [15:0] DEX_alu_result,
   input  logic [15:0] DEX_PC_return,
   input  logic [15:0] DEX_mem_read_addr,
   input  logic [15:0] DEX_mem_write_data,
   input  logic [15:0] DEX_load_immd,
   input  logic [15:0] DEX_reg_data_0,
   input  logic [15:0] DEX_reg_data_1,
   input  logic        dmem_rdy,
   input  logic [15:0] dmem_rdata,
   output logic        dmem_re,
   output logic        dmem_we,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   output logic        we_CPU_0,
   output logic        we_CPU_1,
   output logic [4:0]  wrt_addr_0,
   output logic [4:0]  wrt_addr_1,
   output logic [15:0] wrt_data_0,
   output logic [15:0] wrt_data_1,
   output logic        MEM_STALL,
   output logic        halted,
   output logic        mem_err
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   // Counter value seen in the last ACCESS cycle before the request is dropped.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [1:0]       state_q,      state_d;
   logic [CNT_W-1:0] cnt_q,        cnt_d;
   logic             dmem_re_q,    dmem_re_d;
   logic             dmem_we_q,    dmem_we_d;
   logic [15:0]      dmem_addr_q,  dmem_addr_d;
   logic [15:0]      dmem_wdata_q, dmem_wdata_d;
   logic             we_cpu_0_q,   we_cpu_0_d;
   logic             we_cpu_1_q,   we_cpu_1_d;
   logic [4:0]       wrt_addr_0_q, wrt_addr_0_d;
   logic [4:0]       wrt_addr_1_q, wrt_addr_1_d;
   logic [15:0]      wrt_data_0_q, wrt_data_0_d;
   logic [15:0]      wrt_data_1_q, wrt_data_1_d;
   logic             halted_q,     halted_d;
   logic             mem_err_q,    mem_err_d;
   logic             mem_stall;
   logic             timeout_hit;

   assign timeout_hit = (cnt_q == CNT_LAST);

   always_comb begin
      // NOTE: every signal gets a hold/default value first so no path through
      // the case statement leaves one unassigned (which would infer a latch).
      state_d      = state_q;
      cnt_d        = cnt_q;
      dmem_re_d    = dmem_re_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      we_cpu_0_d   = we_cpu_0_q;
      we_cpu_1_d   = we_cpu_1_q;
      wrt_addr_0_d = wrt_addr_0_q;
      wrt_addr_1_d = wrt_addr_1_q;
      wrt_data_0_d = wrt_data_0_q;
      wrt_data_1_d = wrt_data_1_q;
      halted_d     = halted_q;
      mem_err_d    = mem_err_q;
      mem_stall    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (DEX_halt) begin
               // HALT wins over any memory op carried by the same instruction.
               state_d    = ST_HALTED;
               halted_d   = 1'b1;
               we_cpu_0_d = 1'b0;
               we_cpu_1_d = 1'b0;
            end else if (DEX_mem_re || DEX_mem_we) begin
               mem_stall    = 1'b1;
               state_d      = ST_ACCESS;
               cnt_d        = '0;
               dmem_re_d    = DEX_mem_re;
               // Load takes precedence so the two strobes are never both high.
               dmem_we_d    = DEX_mem_we & ~DEX_mem_re;
               dmem_addr_d  = DEX_mem_read_addr;
               dmem_wdata_d = DEX_mem_write_data;
               we_cpu_0_d   = 1'b0;
               we_cpu_1_d   = 1'b0;
            end else begin
               we_cpu_0_d   = DEX_reg_we_dst_0;
               we_cpu_1_d   = DEX_reg_we_dst_1;
               wrt_addr_0_d = DEX_dst_addr_0;
               wrt_addr_1_d = DEX_dst_addr_1;
               if (DEX_imm_to_reg)      wrt_data_0_d = DEX_load_immd;
               else if (DEX_alu_to_reg) wrt_data_0_d = DEX_alu_result;
               else                     wrt_data_0_d = DEX_reg_data_1;
               wrt_data_1_d = DEX_pcr_to_reg ? DEX_PC_return : DEX_reg_data_0;
            end
         end

         ST_ACCESS: begin
            // Upstream is released on completion and also in the timeout cycle,
            // since the request is dropped at that edge either way.
            mem_stall  = ~dmem_rdy & ~timeout_hit;
            we_cpu_0_d = 1'b0;
            we_cpu_1_d = 1'b0;
            if (dmem_rdy) begin
               state_d   = ST_IDLE;
               dmem_re_d = 1'b0;
               dmem_we_d = 1'b0;
               if (dmem_re_q) begin
                  // The stalled DEX_* values still describe this load.
                  we_cpu_0_d   = DEX_reg_we_dst_0 & DEX_mem_to_reg;
                  wrt_addr_0_d = DEX_dst_addr_0;
                  wrt_data_0_d = dmem_rdata;
               end
            end else if (timeout_hit) begin
               state_d   = ST_IDLE;
               dmem_re_d = 1'b0;
               dmem_we_d = 1'b0;
               mem_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_HALTED: begin
            mem_stall  = 1'b1;
            we_cpu_0_d = 1'b0;
            we_cpu_1_d = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values from before the edge regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         dmem_re_q    <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         we_cpu_0_q   <= 1'b0;
         we_cpu_1_q   <= 1'b0;
         wrt_addr_0_q <= '0;
         wrt_addr_1_q <= '0;
         wrt_data_0_q <= '0;
         wrt_data_1_q <= '0;
         halted_q     <= 1'b0;
         mem_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dmem_re_q    <= dmem_re_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         we_cpu_0_q   <= we_cpu_0_d;
         we_cpu_1_q   <= we_cpu_1_d;
         wrt_addr_0_q <= wrt_addr_0_d;
         wrt_addr_1_q <= wrt_addr_1_d;
         wrt_data_0_q <= wrt_data_0_d;
         wrt_data_1_q <= wrt_data_1_d;
         halted_q     <= halted_d;
         mem_err_q    <= mem_err_d;
      end
   end

   assign dmem_re    = dmem_re_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wdata = dmem_wdata_q;
   assign we_CPU_0   = we_cpu_0_q;
   assign we_CPU_1   = we_cpu_1_q;
   assign wrt_addr_0 = wrt_addr_0_q;
   assign wrt_addr_1 = wrt_addr_1_q;
   assign wrt_data_0 = wrt_data_0_q;
   assign wrt_data_1 = wrt_data_1_q;
   assign MEM_STALL  = mem_stall;
   assign halted     = halted_q;
   assign mem_err    = mem_err_q;

endmodule
